// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: load-size encodings,
// MEM->EX status bus layout and the default sideband width.
package mem_pkg;

  localparam int MEM_PASS_W  = 128;
  localparam int MEM_TO_EX_W = 3;

  localparam int BUS_SRCH  = 2;
  localparam int BUS_EXCEP = 1;
  localparam int BUS_ERTN  = 0;

  typedef enum logic [1:0] {
    LD_W = 2'd0,
    LD_H = 2'd1,
    LD_B = 2'd2
  } ld_size_e;

  function automatic ld_size_e ld_size(input logic ld_b, input logic ld_h);
    if (ld_b) begin
      return LD_B;
    end else if (ld_h) begin
      return LD_H;
    end
    return LD_W;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: selects the byte/half addressed by addr_lo
// and zero- or sign-extends it to 32 bits; words pass through.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic        ld_b,
  input  logic        ld_h,
  input  logic        ld_u,
  output logic [31:0] aligned
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_size(ld_b, ld_h))
      LD_B:    aligned = {{24{~ld_u & byte_v[7]}}, byte_v};
      LD_H:    aligned = {{16{~ld_u & half_v[15]}}, half_v};
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from EX, waits for its data-SRAM
// response (buffering it if WB stalls), aligns load data and hands off to WB.
module mem_stage
  import mem_pkg::*;
#(
  parameter int PASS_W = MEM_PASS_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              ex_to_mem_valid,
  output logic              mem_allowin,
  input  logic [31:0]       ex_pc,
  input  logic              ex_mem_req,
  input  logic              ex_res_from_mem,
  input  logic              ex_rf_we,
  input  logic [4:0]        ex_rf_waddr,
  input  logic [31:0]       ex_alu_result,
  input  logic              ex_ld_b,
  input  logic              ex_ld_h,
  input  logic              ex_ld_u,
  input  logic [1:0]        ex_addr_lo,
  input  logic              ex_excep_en,
  input  logic              ex_ertn_flush,
  input  logic              ex_srch_conflict,
  input  logic [PASS_W-1:0] ex_pass,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              wb_allowin,
  output logic              mem_to_wb_valid,
  output logic [31:0]       mem_pc,
  output logic              mem_rf_we,
  output logic [4:0]        mem_rf_waddr,
  output logic [31:0]       mem_final_result,
  output logic              mem_excep_en,
  output logic              mem_ertn_flush,
  output logic [PASS_W-1:0] mem_pass,
  output logic [MEM_TO_EX_W-1:0] mem_to_ex_bus,
  output logic              mem_fwd_stall
);

  // Handshake: a transfer happens on a cycle where valid and the receiver's
  // allowin are both high; valid never depends on the receiver's allowin.
  logic              mem_valid_q, mem_valid_d;
  logic [31:0]       pc_q, pc_d;
  logic              req_q, req_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       alu_result_q, alu_result_d;
  logic              ld_b_q, ld_b_d, ld_h_q, ld_h_d, ld_u_q, ld_u_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              excep_q, excep_d, ertn_q, ertn_d, srch_q, srch_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [31:0]       rdata_buf_q, rdata_buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic [1:0]        discard_cnt_q, discard_cnt_d;

  logic data_ok_live, ready_go, accept, leave, disc_inc, disc_dec;
  logic [31:0] load_data, aligned;

  always_comb begin
    data_ok_live    = data_sram_data_ok & (discard_cnt_q == 2'd0);
    ready_go        = ~req_q | data_ok_live | buf_valid_q;
    // Held low while reset is asserted so every output reads 0 in reset.
    mem_allowin     = resetn & (~mem_valid_q | (ready_go & wb_allowin));
    mem_to_wb_valid = mem_valid_q & ready_go;
    accept          = ex_to_mem_valid & mem_allowin;
    leave           = mem_to_wb_valid & wb_allowin;

    mem_valid_d = mem_valid_q;
    if (flush) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_to_mem_valid;
    end

    pc_d           = pc_q;
    req_d          = req_q;
    res_from_mem_d = res_from_mem_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    alu_result_d   = alu_result_q;
    ld_b_d         = ld_b_q;
    ld_h_d         = ld_h_q;
    ld_u_d         = ld_u_q;
    addr_lo_d      = addr_lo_q;
    excep_d        = excep_q;
    ertn_d         = ertn_q;
    srch_d         = srch_q;
    pass_d         = pass_q;
    if (accept) begin
      pc_d           = ex_pc;
      req_d          = ex_mem_req;
      res_from_mem_d = ex_res_from_mem;
      rf_we_d        = ex_rf_we;
      rf_waddr_d     = ex_rf_waddr;
      alu_result_d   = ex_alu_result;
      ld_b_d         = ex_ld_b;
      ld_h_d         = ex_ld_h;
      ld_u_d         = ex_ld_u;
      addr_lo_d      = ex_addr_lo;
      excep_d        = ex_excep_en;
      ertn_d         = ex_ertn_flush;
      srch_d         = ex_srch_conflict;
      pass_d         = ex_pass;
    end

    rdata_buf_d = rdata_buf_q;
    buf_valid_d = buf_valid_q;
    if (flush | leave) begin
      buf_valid_d = 1'b0;
    end else if (data_ok_live & mem_valid_q & req_q & ~buf_valid_q & ~wb_allowin) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end

    // A flushed load whose response is still outstanding leaves one response
    // to swallow; a stale strobe arriving in the same cycle cancels out.
    disc_inc      = flush & req_q & mem_valid_q & ~buf_valid_q & ~data_ok_live;
    disc_dec      = data_sram_data_ok & (discard_cnt_q != 2'd0);
    discard_cnt_d = discard_cnt_q;
    if (disc_inc & ~disc_dec) begin
      discard_cnt_d = (discard_cnt_q == 2'd3) ? 2'd3 : discard_cnt_q + 2'd1;
    end else if (disc_dec & ~disc_inc) begin
      discard_cnt_d = discard_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q    <= 1'b0;
      pc_q           <= '0;
      req_q          <= 1'b0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      alu_result_q   <= '0;
      ld_b_q         <= 1'b0;
      ld_h_q         <= 1'b0;
      ld_u_q         <= 1'b0;
      addr_lo_q      <= '0;
      excep_q        <= 1'b0;
      ertn_q         <= 1'b0;
      srch_q         <= 1'b0;
      pass_q         <= '0;
      rdata_buf_q    <= '0;
      buf_valid_q    <= 1'b0;
      discard_cnt_q  <= '0;
    end else begin
      mem_valid_q    <= mem_valid_d;
      pc_q           <= pc_d;
      req_q          <= req_d;
      res_from_mem_q <= res_from_mem_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      alu_result_q   <= alu_result_d;
      ld_b_q         <= ld_b_d;
      ld_h_q         <= ld_h_d;
      ld_u_q         <= ld_u_d;
      addr_lo_q      <= addr_lo_d;
      excep_q        <= excep_d;
      ertn_q         <= ertn_d;
      srch_q         <= srch_d;
      pass_q         <= pass_d;
      rdata_buf_q    <= rdata_buf_d;
      buf_valid_q    <= buf_valid_d;
      discard_cnt_q  <= discard_cnt_d;
    end
  end

  assign load_data = buf_valid_q ? rdata_buf_q : data_sram_rdata;

  load_align u_load_align (
    .rdata   (load_data),
    .addr_lo (addr_lo_q),
    .ld_b    (ld_b_q),
    .ld_h    (ld_h_q),
    .ld_u    (ld_u_q),
    .aligned (aligned)
  );

  always_comb begin
    mem_pc           = pc_q;
    mem_rf_we        = rf_we_q & mem_valid_q;
    mem_rf_waddr     = rf_waddr_q;
    mem_final_result = res_from_mem_q ? aligned : alu_result_q;
    mem_excep_en     = excep_q;
    mem_ertn_flush   = ertn_q;
    mem_pass         = pass_q;
    mem_to_ex_bus            = '0;
    mem_to_ex_bus[BUS_SRCH]  = srch_q & mem_valid_q;
    mem_to_ex_bus[BUS_EXCEP] = excep_q & mem_valid_q;
    mem_to_ex_bus[BUS_ERTN]  = ertn_q & mem_valid_q;
    mem_fwd_stall    = mem_valid_q & res_from_mem_q & ~(data_ok_live | buf_valid_q);
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a reference load model feeds an expected
// queue of WB handoffs, checked every cycle, plus literal per-scenario checks.
module tb_mem_stage;
  localparam int PASS_W = 128;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              ex_to_mem_valid;
  logic              mem_allowin;
  logic [31:0]       ex_pc;
  logic              ex_mem_req, ex_res_from_mem, ex_rf_we;
  logic [4:0]        ex_rf_waddr;
  logic [31:0]       ex_alu_result;
  logic              ex_ld_b, ex_ld_h, ex_ld_u;
  logic [1:0]        ex_addr_lo;
  logic              ex_excep_en, ex_ertn_flush, ex_srch_conflict;
  logic [PASS_W-1:0] ex_pass;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              wb_allowin;
  logic              mem_to_wb_valid;
  logic [31:0]       mem_pc;
  logic              mem_rf_we;
  logic [4:0]        mem_rf_waddr;
  logic [31:0]       mem_final_result;
  logic              mem_excep_en, mem_ertn_flush;
  logic [PASS_W-1:0] mem_pass;
  logic [2:0]        mem_to_ex_bus;
  logic              mem_fwd_stall;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];

  always #5 clk = ~clk;

  mem_stage #(.PASS_W(PASS_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
    .ex_pc(ex_pc), .ex_mem_req(ex_mem_req), .ex_res_from_mem(ex_res_from_mem),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_alu_result(ex_alu_result),
    .ex_ld_b(ex_ld_b), .ex_ld_h(ex_ld_h), .ex_ld_u(ex_ld_u), .ex_addr_lo(ex_addr_lo),
    .ex_excep_en(ex_excep_en), .ex_ertn_flush(ex_ertn_flush),
    .ex_srch_conflict(ex_srch_conflict), .ex_pass(ex_pass),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc),
    .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
    .mem_final_result(mem_final_result), .mem_excep_en(mem_excep_en),
    .mem_ertn_flush(mem_ertn_flush), .mem_pass(mem_pass),
    .mem_to_ex_bus(mem_to_ex_bus), .mem_fwd_stall(mem_fwd_stall)
  );

  // Reference: extract the addressed field arithmetically, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] a,
                                             input logic b, input logic h, input logic u);
    logic [31:0] v;
    int sh;
    if (b) begin
      sh = 8 * int'(a);
      v = (rd >> sh) & 32'h0000_00FF;
      if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (h) begin
      sh = (a >= 2'd2) ? 16 : 0;
      v = (rd >> sh) & 32'h0000_FFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Every WB handoff must match the oldest expected result.
  always @(negedge clk) begin
    if (resetn === 1'b1 && mem_to_wb_valid === 1'b1 && wb_allowin && !flush) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_handoff: got pc 0x%08h expected none", mem_pc);
      end else begin
        check32("wb_result", mem_final_result, exp_q.pop_front());
        check32("wb_pc", mem_pc, exp_pc_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic load, input logic b, input logic h,
                       input logic u, input logic [1:0] a, input logic [31:0] alu,
                       input logic [31:0] exp, input logic push);
    int n;
    ex_to_mem_valid = 1'b1;
    ex_pc = pc;
    ex_mem_req = load;
    ex_res_from_mem = load;
    ex_rf_we = 1'b1;
    ex_rf_waddr = pc[6:2];
    ex_alu_result = alu;
    ex_ld_b = b;
    ex_ld_h = h;
    ex_ld_u = u;
    ex_addr_lo = a;
    #1;
    n = 0;
    while (!mem_allowin && n < 20) begin
      cycle();
      n++;
    end
    if (n == 20) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_timeout: got allowin 0 expected 1 within 20 cycles");
    end
    if (push) begin
      exp_q.push_back(exp);
      exp_pc_q.push_back(pc);
    end
    cycle();
    ex_to_mem_valid = 1'b0;
    ex_excep_en = 1'b0;
    ex_ertn_flush = 1'b0;
    ex_srch_conflict = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [PASS_W-1:0] pat;
    resetn = 1'b0; flush = 1'b0; ex_to_mem_valid = 1'b0; ex_pc = '0;
    ex_mem_req = 1'b0; ex_res_from_mem = 1'b0; ex_rf_we = 1'b0; ex_rf_waddr = '0;
    ex_alu_result = '0; ex_ld_b = 1'b0; ex_ld_h = 1'b0; ex_ld_u = 1'b0; ex_addr_lo = '0;
    ex_excep_en = 1'b0; ex_ertn_flush = 1'b0; ex_srch_conflict = 1'b0; ex_pass = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A_5A5A; wb_allowin = 1'b1;
    #12;
    check1("rst_allowin", mem_allowin, 1'b0);
    check1("rst_to_wb_valid", mem_to_wb_valid, 1'b0);
    check32("rst_result", mem_final_result, 32'h0);
    check32("rst_bus", {29'b0, mem_to_ex_bus}, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    settle();
    check1("post_rst_allowin", mem_allowin, 1'b1);
    cycle();

    // 1: ld.b / ld.bu, data_ok in first MEM cycle
    issue(32'h100, 1, 1, 0, 0, 2'd2, 32'h1000_0002, model_load(32'h12F4_5678, 2'd2, 1, 0, 0), 1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12F4_5678;
    settle();
    check32("t1_ldb_result", mem_final_result, 32'hFFFF_FFF4);
    check1("t1_ldb_valid", mem_to_wb_valid, 1'b1);
    check1("t1_rf_we", mem_rf_we, 1'b1);
    cycle();
    data_sram_data_ok = 1'b0;
    settle();
    check1("t1_one_cycle", mem_to_wb_valid, 1'b0);
    issue(32'h104, 1, 1, 0, 1, 2'd2, 32'h1000_0002, model_load(32'h12F4_5678, 2'd2, 1, 0, 1), 1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12F4_5678;
    settle();
    check32("t1_ldbu_result", mem_final_result, 32'h0000_00F4);
    cycle();
    data_sram_data_ok = 1'b0;

    // 2: ld.h, response three cycles late
    issue(32'h108, 1, 0, 1, 0, 2'd2, 32'h2000_0002, model_load(32'h8001_5555, 2'd2, 0, 1, 0), 1);
    for (int i = 0; i < 3; i++) begin
      settle();
      check1("t2_stall", mem_fwd_stall, 1'b1);
      check1("t2_allowin", mem_allowin, 1'b0);
      cycle();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_5555;
    settle();
    check32("t2_ldh_result", mem_final_result, 32'hFFFF_8001);
    check1("t2_stall_release", mem_fwd_stall, 1'b0);
    cycle();
    data_sram_data_ok = 1'b0;

    // 3: response while WB stalled is buffered across a bus change
    issue(32'h10C, 1, 0, 0, 0, 2'd0, 32'h3000_0000, model_load(32'hCAFE_BABE, 2'd0, 0, 0, 0), 1);
    wb_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_BABE;
    settle();
    check1("t3_allowin_blocked", mem_allowin, 1'b0);
    cycle();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1111_1111;
    settle();
    check32("t3_buffered", mem_final_result, 32'hCAFE_BABE);
    check1("t3_buf_nostall", mem_fwd_stall, 1'b0);
    cycle();
    wb_allowin = 1'b1;
    settle();
    check32("t3_handoff", mem_final_result, 32'hCAFE_BABE);
    cycle();
    issue(32'h110, 1, 0, 0, 0, 2'd0, 32'h0, model_load(32'h0BAD_F00D, 2'd0, 0, 0, 0), 1);
    settle();
    check1("t3_buf_cleared", mem_fwd_stall, 1'b1);
    cycle();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
    cycle();
    data_sram_data_ok = 1'b0;

    // 4: flush while waiting; next load skips the stale response
    issue(32'h114, 1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 0);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    settle();
    check1("t4_flushed_valid", mem_to_wb_valid, 1'b0);
    check1("t4_flushed_allowin", mem_allowin, 1'b1);
    issue(32'h118, 1, 0, 0, 0, 2'd0, 32'h0, model_load(32'h0000_1234, 2'd0, 0, 0, 0), 1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_0000;
    settle();
    check1("t4_stale_dropped", mem_to_wb_valid, 1'b0);
    check1("t4_stale_stall", mem_fwd_stall, 1'b1);
    cycle();
    data_sram_data_ok = 1'b0;
    cycle();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_1234;
    settle();
    check32("t4_result", mem_final_result, 32'h0000_1234);
    cycle();
    data_sram_data_ok = 1'b0;

    // 5: flush coincident with data_ok must not arm the discard counter
    issue(32'h11C, 1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 0);
    flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_5555;
    cycle();
    flush = 1'b0; data_sram_data_ok = 1'b0;
    issue(32'h120, 1, 0, 0, 0, 2'd0, 32'h0, model_load(32'h0000_BEEF, 2'd0, 0, 0, 0), 1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_BEEF;
    settle();
    check1("t5_no_discard", mem_to_wb_valid, 1'b1);
    check32("t5_result", mem_final_result, 32'h0000_BEEF);
    cycle();
    data_sram_data_ok = 1'b0;

    // 6: status bus for a non-memory instruction, then reset mid-wait
    pat = {32'hA5A5_0001, 32'h1234_5678, 32'h0F0F_F0F0, 32'($urandom_range(0, 32'hFFFF))};
    ex_pass = pat; ex_excep_en = 1'b1; ex_srch_conflict = 1'b1;
    issue(32'h124, 0, 0, 0, 0, 2'd0, 32'h0000_55AA, 32'h0000_55AA, 1);
    settle();
    check32("t6_bus", {29'b0, mem_to_ex_bus}, 32'h6);
    check1("t6_excep", mem_excep_en, 1'b1);
    check1("t6_nonmem_valid", mem_to_wb_valid, 1'b1);
    check32("t6_pass_lo", mem_pass[31:0], pat[31:0]);
    check32("t6_pass_hi", mem_pass[127:96], pat[127:96]);
    cycle();
    issue(32'h128, 1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 0);
    cycle();
    resetn = 1'b0;
    #1;
    check1("t6_rst_valid", mem_to_wb_valid, 1'b0);
    check1("t6_rst_allowin", mem_allowin, 1'b0);
    check32("t6_rst_pc", mem_pc, 32'h0);
    check1("t6_rst_stall", mem_fwd_stall, 1'b0);
    check1("t6_rst_rf_we", mem_rf_we, 1'b0);
    check32("t6_rst_pass", mem_pass[31:0], 32'h0);
    cycle();
    resetn = 1'b1;
    settle();
    check1("t6_rst_release", mem_allowin, 1'b1);
    cycle();
    issue(32'h12C, 1, 0, 1, 1, 2'd0, 32'h0, model_load(32'h7777_9ABC, 2'd0, 0, 1, 1), 1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_9ABC;
    settle();
    check32("t6_ldhu_result", mem_final_result, 32'h0000_9ABC);
    cycle();
    data_sram_data_ok = 1'b0;
    cycle();

    check32("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
